// File: rtl/mult_sequencer.sv
// Control sequencer for the add-shift signed multiplier datapath (X:A:B + 9-bit add/sub).
// Latency: CLR one cycle after Run is sampled low, then WIDTH add/shift pairs; Done after edge 2*WIDTH+1.
// Backpressure: none; holds in DONE until Run is released, ignores ClearA_LoadB outside IDLE.
//
// Ports:
//   Clk, Reset (sync, active-low)  clock and reset
//   Run, ClearA_LoadB              operator buttons, active-low
//   M                              current LSB of register B from the datapath
//   Clear_XA, Ld_B, Add_En,
//   Sub_Sel, Shift_En              per-cycle datapath strobes
//   Busy, Done                     operation status
//   Count                          iteration index, 0..WIDTH-1
module mult_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clear_XA,
  output logic          Ld_B,
  output logic          Add_En,
  output logic          Sub_Sel,
  output logic          Shift_En,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state_q;
  logic [CW-1:0] count_q;

  logic last_iter;
  assign last_iter = (count_q == LAST);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Run takes priority over the load button.
          if (!Run) begin
            state_q <= CLR;
            count_q <= '0;
          end
        end
        CLR:   state_q <= ADD;
        // The add phase always takes its cycle, even when M=0, so timing is data-independent.
        ADD:   state_q <= SHIFT;
        SHIFT: begin
          if (last_iter) begin
            state_q <= DONE;
          end else begin
            count_q <= count_q + CW'(1);
            state_q <= ADD;
          end
        end
        DONE: begin
          // Re-arm only after the start button is released.
          if (Run) begin
            state_q <= IDLE;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  logic load_req;
  assign load_req = (state_q == IDLE) && Run && !ClearA_LoadB;

  assign Ld_B     = load_req;
  // Loading B also clears X:A so a fresh multiplier starts from zero.
  assign Clear_XA = load_req || (state_q == CLR);
  assign Add_En   = (state_q == ADD) && M;
  // Final bit carries negative weight in two's complement, so that partial product is subtracted.
  assign Sub_Sel  = (state_q == ADD) && M && last_iter;
  assign Shift_En = (state_q == SHIFT);
  assign Busy     = (state_q == CLR) || (state_q == ADD) || (state_q == SHIFT);
  assign Done     = (state_q == DONE);
  assign Count    = count_q;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Run;
  logic          ClearA_LoadB;
  logic          M;
  logic          Clear_XA, Ld_B, Add_En, Sub_Sel, Shift_En, Busy, Done;
  logic [CW-1:0] Count;

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clear_XA(Clear_XA), .Ld_B(Ld_B), .Add_En(Add_En), .Sub_Sel(Sub_Sel),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Behavioural X:A:B datapath with 9-bit adder/subtractor driven by the strobes.
  logic       X;
  logic [7:0] A, B, sw;
  logic [8:0] sum;
  assign M   = B[0];
  assign sum = Sub_Sel ? ({A[7], A} - {sw[7], sw}) : ({A[7], A} + {sw[7], sw});

  always @(posedge Clk) begin
    if (Ld_B) B <= sw;
    if (Clear_XA) begin
      X <= 1'b0;
      A <= 8'h00;
    end else if (Add_En) begin
      X <= sum[8];
      A <= sum[7:0];
    end else if (Shift_En) begin
      A <= {X, A[7:1]};
      B <= {A[0], B[7:1]};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Per-operation statistics gathered once per cycle.
  int cyc, n_busy, n_shift, n_add, n_sub, n_sub_bad, n_clr, n_ldb, n_excl, first_done;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_busy = 0; n_shift = 0; n_add = 0; n_sub = 0; n_sub_bad = 0;
    n_clr = 0; n_ldb = 0; n_excl = 0; first_done = -1;
  endtask

  // Advance one cycle and observe outputs away from the rising edge.
  task automatic step();
    @(negedge Clk);
    cyc++;
    if (Busy) n_busy++;
    if (Shift_En) n_shift++;
    if (Add_En) n_add++;
    if (Sub_Sel) begin
      n_sub++;
      if (Count != CW'(WIDTH - 1)) n_sub_bad++;
    end
    if (Clear_XA) n_clr++;
    if (Ld_B) n_ldb++;
    if (int'(Clear_XA) + int'(Add_En) + int'(Shift_En) > 1) n_excl++;
    if (Done && first_done < 0) first_done = cyc;
  endtask

  // Load B from the switches with a one-cycle button press.
  task automatic load_b(input logic [7:0] val);
    sw = val;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
  endtask

  // Pulse Run for one sampling edge and run the operation out to IDLE.
  task automatic run_op(input logic [7:0] mcand);
    sw = mcand;
    Run = 1'b0;
    clear_stats();
    step();
    Run = 1'b1;
    repeat (20) step();
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b1; ClearA_LoadB = 1'b1; sw = 8'h00;
    X = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_count", Count, 0);
    check("rst_strobes", {Clear_XA, Ld_B, Add_En, Sub_Sel, Shift_En}, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // 1: load button in IDLE, one cycle
    sw = 8'hFF;
    ClearA_LoadB = 1'b0;
    #1;
    check("t1_ldb", Ld_B, 1);
    check("t1_clrxa", Clear_XA, 1);
    check("t1_busy", Busy, 0);
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    #1;
    check("t1_ldb_off", Ld_B, 0);
    check("t1_clrxa_off", Clear_XA, 0);
    check("t1_count", Count, 0);
    check("t1_b", B, 8'hFF);

    // 2: M=1 in every ADD cycle (B=0xFF = -1), multiplicand 3
    run_op(8'h03);
    check("t2_add", n_add, 8);
    check("t2_sub", n_sub, 1);
    check("t2_sub_cnt", n_sub_bad, 0);
    check("t2_shift", n_shift, 8);
    check("t2_done_cyc", first_done, 18);
    check("t2_busy", n_busy, 17);
    check("t2_clr", n_clr, 1);
    check("t2_excl", n_excl, 0);
    check("t2_prod", {A, B}, 16'hFFFD);

    // 3: M=0 in every ADD cycle, then signed products through the datapath
    load_b(8'h00);
    run_op(8'h55);
    check("t3_add", n_add, 0);
    check("t3_sub", n_sub, 0);
    check("t3_shift", n_shift, 8);
    check("t3_done_cyc", first_done, 18);
    check("t3_prod0", {A, B}, 0);
    load_b(8'hFD);
    run_op(8'h07);
    check("t3_prod_neg", {A, B}, 16'hFFEB);
    load_b(8'h80);
    run_op(8'h80);
    check("t3_prod_min", {A, B}, 16'h4000);
    check("t3_sub_min", n_sub, 1);

    // 4: Run held low long past Done
    Run = 1'b0;
    clear_stats();
    repeat (28) step();
    check("t4_done", Done, 1);
    check("t4_busy", Busy, 0);
    check("t4_one_clr", n_clr, 1);
    check("t4_count", Count, WIDTH - 1);
    Run = 1'b1;
    step();
    check("t4_idle_done", Done, 0);
    check("t4_idle_count", Count, 0);
    Run = 1'b0;
    step();
    check("t4_rearm_clr", Clear_XA, 1);
    check("t4_rearm_busy", Busy, 1);
    check("t4_rearm_count", Count, 0);
    Run = 1'b1;
    repeat (20) step();

    // 5: reset during SHIFT with Count=3
    Run = 1'b0;
    clear_stats();
    step();
    Run = 1'b1;
    repeat (8) step();
    check("t5_in_shift", Shift_En, 1);
    check("t5_cnt3", Count, 3);
    Reset = 1'b0;
    step();
    check("t5_busy", Busy, 0);
    check("t5_count", Count, 0);
    check("t5_strobes", {Clear_XA, Ld_B, Add_En, Sub_Sel, Shift_En, Done}, 0);
    Reset = 1'b1;
    run_op(8'h01);
    check("t5_full_busy", n_busy, 17);
    check("t5_full_shift", n_shift, 8);
    check("t5_full_done", first_done, 18);

    // 6: Run and load pressed together; load held through the operation
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    clear_stats();
    #1;
    check("t6_ldb_pri", Ld_B, 0);
    step();
    check("t6_clr", Clear_XA, 1);
    Run = 1'b1;
    repeat (17) step();
    check("t6_no_ldb", n_ldb, 0);
    check("t6_busy", n_busy, 17);
    check("t6_shift", n_shift, 8);
    check("t6_one_clr", n_clr, 1);
    check("t6_done", first_done, 18);
    ClearA_LoadB = 1'b1;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Counter-based sequencer for the add-shift signed multiplier datapath (register unit X:A:B plus 9-bit adder/subtractor).
- Drives per-cycle control strobes to that datapath: one add phase and one shift phase per multiplier bit, with subtract on the final (sign) bit.
- Handles the operator buttons: load B, start, and re-arm only after the start button is released.
- Width-parameterised, so the same block sequences 4-bit and 8-bit builds.

Parameters:
- WIDTH, 8, number of multiplier bits, i.e. add/shift iterations (legal range 2..16).
- CW, $clog2(WIDTH)+1, width of the iteration counter; derived, never overridden.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Run  in  1  start button, active-low (0 = pressed).
- ClearA_LoadB  in  1  load button, active-low (0 = pressed).
- M  in  1  current LSB of register B, from the datapath.
- Clear_XA  out  1  clear X and A this cycle.
- Ld_B  out  1  load switches into B this cycle.
- Add_En  out  1  load adder result into X:A this cycle.
- Sub_Sel  out  1  adder performs A - S instead of A + S.
- Shift_En  out  1  arithmetic right shift of X:A:B this cycle.
- Busy  out  1  multiplication in progress.
- Done  out  1  result valid, waiting for Run release.
- Count  out  CW  iteration index, 0..WIDTH-1.

Behaviour:
- Reset: Reset sampled 0 at an edge puts the state in IDLE and Count at 0 on that edge, from any state including mid-operation. After reset, all outputs are 0 unless ClearA_LoadB is low (IDLE rule below applies).
- States: IDLE, CLR, ADD, SHIFT, DONE. The state register and Count are the only storage.
- IDLE:
  - Run=0 → next CLR; Count <= 0.
  - If Run=1 and ClearA_LoadB=0, then Ld_B=1 and Clear_XA=1 combinationally this cycle, and state stays IDLE.
  - If Run=0 and ClearA_LoadB=0 together, Run wins: Ld_B=0, and only CLR is entered.
- CLR: Clear_XA=1 for exactly one cycle; Busy=1; next state ADD.
- ADD:
  - Busy=1.
  - Add_En=M (combinational).
  - Sub_Sel=M when Count==WIDTH-1, else 0.
  - Next state SHIFT unconditionally; no add is skipped in time, even when M=0.
- SHIFT:
  - Shift_En=1; Busy=1.
  - If Count==WIDTH-1 → next DONE, and Count holds.
  - Otherwise Count <= Count+1 and next state ADD.
- DONE:
  - Done=1; Busy=0; no strobes.
  - Stays in DONE while Run=0.
  - Run=1 → next IDLE with Count <= 0.
- Strobe exclusivity: Clear_XA, Add_En and Shift_En are never high together. Ld_B is high only in IDLE.
- ClearA_LoadB is ignored in every state except IDLE.
- Timing: with the Run=0 sampling edge as edge 0:
  - CLR occupies cycle 1.
  - ADD_i occupies cycle 2+2i; SHIFT_i occupies cycle 3+2i.
  - Done first asserts after edge 2*WIDTH+1, which is edge 17 for WIDTH=8.
  - Busy is high for exactly 2*WIDTH+1 cycles.
  - Exactly WIDTH Shift_En pulses per operation.
- Count never exceeds WIDTH-1. There is no wrap-around.
- Outputs are decoded from the state register except Add_En/Sub_Sel (depend on M) and Ld_B/Clear_XA in IDLE (depend on ClearA_LoadB). The datapath must present a stable M before the edge.

Test Plan:
1. Reset, Run=1, ClearA_LoadB=0 for 1 cycle → Ld_B=1 and Clear_XA=1 for that cycle only; Busy=0; state stays IDLE; Count=0.
2. WIDTH=8, M=1 every ADD cycle (B=0xFF), Run pulsed low → Add_En high in all 8 ADD cycles; Sub_Sel high only in ADD with Count=7; 8 Shift_En pulses; Done first high after edge 17; Busy high 17 cycles.
3. M=0 in every ADD cycle → Add_En and Sub_Sel never high; 8 Shift_En pulses; Done after edge 17. With the datapath attached: 0x07*0xFD gives X:A:B = 0xFFEB (-21), and 0x80*0x80 gives 0x4000.
4. Run held low 10 cycles past Done → stays in DONE, no second CLR. Run=1 → IDLE next edge. Run=0 → CLR again and Count=0.
5. Reset=0 sampled during SHIFT with Count=3 → next state IDLE, Count=0, all strobes 0. A subsequent Run press gives a full 17-cycle operation.
6. Run=0 and ClearA_LoadB=0 in the same IDLE cycle → CLR entered and Ld_B never asserted. ClearA_LoadB=0 while Busy → no Ld_B and no effect on the sequence.
